// File: rtl/aes_pkg.sv
// Shared AES-128 constants, types and GF(2^8) helpers used by the round datapath
// and the on-the-fly key schedule.
package aes_pkg;

    localparam int AES_NUM_ROUNDS = 10;
    localparam int STATE_W        = 128;
    localparam int WORD_W         = 32;

    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_POLY = 8'h1B;

    typedef logic [STATE_W-1:0] state_t;
    typedef logic [WORD_W-1:0]  word_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } rka_state_e;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/round_key_adder_if.sv
// Handshake bundle between the round mux, the AddRoundKey stage and its consumer.
interface round_key_adder_if;
    import aes_pkg::*;

    logic       key_load;
    state_t     cipher_key;
    state_t     state_in;
    logic       in_valid;
    logic       in_ready;
    state_t     state_out;
    logic [3:0] out_round;
    logic       out_last;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output key_load, cipher_key, state_in, in_valid, out_ready,
        input  in_ready, state_out, out_round, out_last, out_valid
    );

    modport slave (
        input  key_load, cipher_key, state_in, in_valid, out_ready,
        output in_ready, state_out, out_round, out_last, out_valid
    );

endinterface

// File: rtl/aes_sbox.sv
// AES forward S-box: multiplicative inverse in GF(2^8) (as x^254) followed by the affine map.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    logic [7:0] inv_s;

    // x^(2^k-1) ladder up to x^127, one final squaring gives x^254 (and maps 0 to 0).
    always_comb begin
        inv_s = in_byte;
        for (int i = 0; i < 6; i++) begin
            inv_s = gf_mul(gf_mul(inv_s, inv_s), in_byte);
        end
        inv_s    = gf_mul(inv_s, inv_s);
        out_byte = inv_s
                 ^ {inv_s[6:0], inv_s[7]}
                 ^ {inv_s[5:0], inv_s[7:6]}
                 ^ {inv_s[4:0], inv_s[7:5]}
                 ^ {inv_s[3:0], inv_s[7:4]}
                 ^ 8'h63;
    end

endmodule

// File: rtl/key_schedule_step.sv
// One AES-128 key expansion step: current round key and rcon in, next round key and rcon out.
module key_schedule_step
    import aes_pkg::*;
(
    input  state_t     rk,
    input  logic [7:0] rcon,
    output state_t     next_rk,
    output logic [7:0] next_rcon
);

    word_t rot_s;
    word_t sub_s;
    word_t temp_s;
    word_t w0_s, w1_s, w2_s, w3_s;

    assign rot_s = rot_word(rk[31:0]);

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte  (rot_s[8*g +: 8]),
            .out_byte (sub_s[8*g +: 8])
        );
    end

    // Chained word XORs of the key expansion.
    always_comb begin
        temp_s    = sub_s ^ {rcon, 24'h000000};
        w0_s      = rk[127:96] ^ temp_s;
        w1_s      = rk[95:64]  ^ w0_s;
        w2_s      = rk[63:32]  ^ w1_s;
        w3_s      = rk[31:0]   ^ w2_s;
        next_rk   = {w0_s, w1_s, w2_s, w3_s};
        next_rcon = xtime(rcon);
    end

endmodule

// File: rtl/round_key_adder.sv
// Registered AddRoundKey stage with an on-the-fly AES-128 key schedule; one state per
// cycle through a single output register.
module round_key_adder
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES_NUM_ROUNDS
)(
    input  logic clk,
    input  logic rst,
    round_key_adder_if.slave bus
);

    rka_state_e fsm_r, fsm_nxt_s;
    state_t     rk_r;
    logic [7:0] rcon_r;
    logic [3:0] round_cnt_r;
    state_t     state_out_r;
    logic [3:0] out_round_r;
    logic       out_last_r;
    logic       out_valid_r;

    logic       in_ready_s;
    logic       accept_s;
    logic       last_round_s;
    state_t     next_rk_s;
    logic [7:0] next_rcon_s;

    assign last_round_s = (round_cnt_r == 4'(NUM_ROUNDS));

    key_schedule_step u_ks (
        .rk        (rk_r),
        .rcon      (rcon_r),
        .next_rk   (next_rk_s),
        .next_rcon (next_rcon_s)
    );

    // Next state and input handshake.
    always_comb begin
        fsm_nxt_s  = fsm_r;
        in_ready_s = 1'b0;
        accept_s   = 1'b0;
        case (fsm_r)
            IDLE: begin
                if (bus.key_load) fsm_nxt_s = RUN;
                else              fsm_nxt_s = IDLE;
            end
            RUN: begin
                in_ready_s = ~out_valid_r | bus.out_ready;
                accept_s   = bus.in_valid & in_ready_s;
                if (accept_s && last_round_s) fsm_nxt_s = IDLE;
                else                          fsm_nxt_s = RUN;
            end
            default: fsm_nxt_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) fsm_r <= IDLE;
        else     fsm_r <= fsm_nxt_s;
    end

    // Round key, rcon and round counter; a key_load outside IDLE is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rk_r        <= '0;
            rcon_r      <= RCON_INIT;
            round_cnt_r <= 4'd0;
        end else if (fsm_r == IDLE && bus.key_load) begin
            rk_r        <= bus.cipher_key;
            rcon_r      <= RCON_INIT;
            round_cnt_r <= 4'd0;
        end else if (accept_s) begin
            rk_r        <= next_rk_s;
            rcon_r      <= next_rcon_s;
            round_cnt_r <= round_cnt_r + 4'd1;
        end
    end

    // Output register: reloads on accept, clears only when consumed without a reload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_out_r <= '0;
            out_round_r <= 4'd0;
            out_last_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (accept_s) begin
            state_out_r <= bus.state_in ^ rk_r;
            out_round_r <= round_cnt_r;
            out_last_r  <= last_round_s;
            out_valid_r <= 1'b1;
        end else if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.state_out = state_out_r;
    assign bus.out_round = out_round_r;
    assign bus.out_last  = out_last_r;
    assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_round_key_adder.sv
// Scoreboard bench for round_key_adder using the FIPS-197 App. B key and round keys.
module tb_round_key_adder;

    localparam logic [127:0] KEY    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY2   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT     = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] R1_IN  = 128'h046681e5e0cb199a48f8d37a2806264c;
    // Column-major round-10 input (after ShiftRows) from App. B.
    localparam logic [127:0] R10_IN = 128'he9317db5cb322c723d2e895faf090794;
    localparam logic [127:0] R0_OUT = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] R1_OUT = 128'ha49c7ff2689f352b6b5bea43026a5049;
    localparam logic [127:0] CT     = 128'h3925841d02dc09fbdc118597196a0b32;

    typedef struct {
        logic [127:0] st;
        logic [3:0]   rnd;
        logic         last;
    } exp_t;

    logic clk;
    logic rst;
    round_key_adder_if bus ();

    round_key_adder #(.NUM_ROUNDS(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t         sb[$];
    logic [127:0] rk_tbl [0:10];
    logic [127:0] last_exp;
    logic [127:0] hold_val;
    int           n_checks = 0;
    int           n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Scoreboard consumer: one pop per consumed output.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check_value("sb_underflow", 128'(sb.size()), 128'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_value("sb_state", bus.state_out, e.st);
                check_value("sb_round", 128'(bus.out_round), 128'(e.rnd));
                check_value("sb_last",  128'(bus.out_last),  128'(e.last));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [127:0] state_for(input int r);
        if (r == 0)       return PT;
        else if (r == 1)  return R1_IN;
        else if (r == 10) return R10_IN;
        else              return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic send(input logic [127:0] st, input int r);
        bit done;
        exp_t e;
        done         = 1'b0;
        bus.state_in = st;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                e.st   = st ^ rk_tbl[r];
                e.rnd  = 4'(r);
                e.last = (r == 10);
                sb.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        check_value("send_accepted", 128'(done), 128'd1);
    endtask

    task automatic load_key(input logic [127:0] k);
        bus.cipher_key = k;
        bus.key_load   = 1'b1;
        @(posedge clk);
        #1;
        bus.key_load   = 1'b0;
    endtask

    task automatic run_block(input int lo, input int hi);
        logic [127:0] st;
        for (int r = lo; r <= hi; r++) begin
            st = state_for(r);
            send(st, r);
            last_exp = st ^ rk_tbl[r];
            if (r == 0) begin
                check_value("r0_valid", 128'(bus.out_valid), 128'd1);
                check_value("r0_state", bus.state_out, R0_OUT);
                check_value("r0_round", 128'(bus.out_round), 128'd0);
                check_value("r0_last",  128'(bus.out_last), 128'd0);
            end
            if (r == 1) check_value("r1_state", bus.state_out, R1_OUT);
            if (r == 10) begin
                check_value("r10_state",    bus.state_out, CT);
                check_value("r10_last",     128'(bus.out_last), 128'd1);
                check_value("r10_in_ready", 128'(bus.in_ready), 128'd0);
            end
        end
    endtask

    initial begin
        rk_tbl[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        rk_tbl[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        rk_tbl[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        rk_tbl[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        rk_tbl[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        rk_tbl[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        rk_tbl[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        rk_tbl[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        rk_tbl[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        rk_tbl[9]  = 128'hac7766f319fadc2128d12941575c006e;
        rk_tbl[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        rst            = 1'b1;
        bus.key_load   = 1'b0;
        bus.cipher_key = '0;
        bus.state_in   = '0;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_value("rst_state_out", bus.state_out, 128'd0);
        check_value("rst_out_round", 128'(bus.out_round), 128'd0);
        check_value("rst_out_last",  128'(bus.out_last), 128'd0);
        check_value("rst_out_valid", 128'(bus.out_valid), 128'd0);
        check_value("rst_in_ready",  128'(bus.in_ready), 128'd0);
        rst = 1'b0;

        // in_valid while IDLE is ignored.
        bus.state_in = {$urandom, $urandom, $urandom, $urandom};
        bus.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_value("idle_in_ready",  128'(bus.in_ready), 128'd0);
            check_value("idle_out_valid", 128'(bus.out_valid), 128'd0);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;

        load_key(KEY);
        run_block(0, 10);

        // Backpressure after round 3, ignored key_load during round 5.
        load_key(KEY);
        run_block(0, 3);
        hold_val      = last_exp;
        bus.out_ready = 1'b0;
        bus.state_in  = state_for(4);
        bus.in_valid  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_value("bp_in_ready",  128'(bus.in_ready), 128'd0);
            check_value("bp_out_valid", 128'(bus.out_valid), 128'd1);
            check_value("bp_hold",      bus.state_out, hold_val);
            check_value("bp_round",     128'(bus.out_round), 128'd3);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        run_block(4, 4);
        bus.cipher_key = KEY2;
        bus.key_load   = 1'b1;
        run_block(5, 5);
        bus.key_load   = 1'b0;
        run_block(6, 10);

        // key_load in IDLE with the final output still pending.
        bus.out_ready = 1'b0;
        load_key(KEY);
        check_value("pend_state", bus.state_out, CT);
        check_value("pend_valid", 128'(bus.out_valid), 128'd1);
        check_value("pend_in_ready", 128'(bus.in_ready), 128'd0);
        bus.out_ready = 1'b1;

        // Reset at round 6.
        run_block(0, 5);
        bus.state_in = state_for(6);
        bus.in_valid = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        check_value("mid_rst_state_out", bus.state_out, 128'd0);
        check_value("mid_rst_out_round", 128'(bus.out_round), 128'd0);
        check_value("mid_rst_out_valid", 128'(bus.out_valid), 128'd0);
        check_value("mid_rst_in_ready",  128'(bus.in_ready), 128'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_value("post_rst_out_valid", 128'(bus.out_valid), 128'd0);
            check_value("post_rst_in_ready",  128'(bus.in_ready), 128'd0);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        load_key(KEY);
        run_block(0, 10);

        repeat (3) @(negedge clk);
        check_value("sb_drain", 128'(sb.size()), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
